operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 30 +++
 rtl/operand_fetch.sv | 119 +++++++++++
 tb/tb_operand_fetch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Issue-stage bus: instruction in, ALU issue slot out, writeback in.
// The master drives instructions and writeback; the slave is the fetch stage.
interface operand_fetch_if;
    logic        in_valid;
    logic [10:0] in_instr;
    logic        in_ready;
    logic [4:0]  alu_a;
    logic [4:0]  alu_b;
    logic [1:0]  alu_control;
    logic [2:0]  alu_rd;
    logic        alu_valid;
    logic        out_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [9:0]  wb_data;

    modport master (
        output in_valid, in_instr, out_ready,
        output wb_en, wb_addr, wb_data,
        input  in_ready, alu_a, alu_b, alu_control,
        input  alu_rd, alu_valid
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        input  wb_en, wb_addr, wb_data,
        output in_ready, alu_a, alu_b, alu_control,
        output alu_rd, alu_valid
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: 8x5 register file, pending scoreboard, writeback
// bypass and a single registered ALU issue slot.
module operand_fetch (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    typedef struct packed {
        logic [1:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] a;
        logic [4:0] b;
        logic [1:0] ctrl;
        logic [2:0] rd;
    } slot_t;

    instr_t     ins;
    slot_t      slot;
    logic [4:0] rf [8];
    logic [7:0] pending;

    logic       wb_hit;
    logic [4:0] wb_val;
    logic [7:0] wb_mask;
    logic [7:0] set_mask;
    logic [7:0] pend_eff;
    logic [4:0] opa;
    logic [4:0] opb;
    logic       slot_free;
    logic       hazard;
    logic       accept;
    logic       consume;
    logic       unused_wb_hi;

    assign ins    = instr_t'(bus.in_instr);
    assign wb_hit = bus.wb_en && (bus.wb_addr != 3'd0);
    assign wb_val = bus.wb_data[4:0];

    assign unused_wb_hi = ^bus.wb_data[9:5];

    always_comb begin
        wb_mask = '0;
        if (wb_hit)
            wb_mask[bus.wb_addr] = 1'b1;
    end

    always_comb begin
        set_mask = '0;
        if (accept && (ins.rd != 3'd0))
            set_mask[ins.rd] = 1'b1;
    end

    // A writeback landing this cycle already resolves its register.
    assign pend_eff = pending & ~wb_mask;

    assign slot_free = !slot.valid || bus.out_ready;
    assign hazard    = bus.in_valid &&
                       (pend_eff[ins.rs] ||
                        pend_eff[ins.rt] ||
                        pend_eff[ins.rd]);
    assign accept    = bus.in_valid && slot_free && !hazard;
    assign consume   = slot.valid && bus.out_ready;

    always_comb begin
        opa = '0;
        if (ins.rs != 3'd0) begin
            if (wb_hit && (bus.wb_addr == ins.rs))
                opa = wb_val;
            else
                opa = rf[ins.rs];
        end
    end

    always_comb begin
        opb = '0;
        if (ins.rt != 3'd0) begin
            if (wb_hit && (bus.wb_addr == ins.rt))
                opb = wb_val;
            else
                opb = rf[ins.rt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
            pending <= '0;
            slot    <= '0;
        end else begin
            if (wb_hit)
                rf[bus.wb_addr] <= wb_val;
            // A new claim on rd outranks a same-cycle clear of it.
            pending <= (pend_eff | set_mask) & 8'hFE;
            if (accept) begin
                slot.valid <= 1'b1;
                slot.a     <= opa;
                slot.b     <= opb;
                slot.ctrl  <= ins.op;
                slot.rd    <= ins.rd;
            end else if (consume) begin
                slot.valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = slot_free && !hazard;
    assign bus.alu_valid   = slot.valid;
    assign bus.alu_a       = slot.a;
    assign bus.alu_b       = slot.b;
    assign bus.alu_control = slot.ctrl;
    assign bus.alu_rd      = slot.rd;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazards, bypass, stalls, reset.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_operand_fetch;
    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] op,
                         input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt);
        bus.in_valid = v;
        bus.in_instr = {op, rd, rs, rt};
    endtask

    task automatic wb(input logic en, input logic [2:0] addr,
                      input logic [9:0] data);
        bus.wb_en   = en;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.out_ready = 1'b1;
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        wb(1'b0, 3'd0, 10'd0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", 32'(bus.alu_valid), 32'd0);
        check("rst_a", 32'(bus.alu_a), 32'd0);
        check("rst_b", 32'(bus.alu_b), 32'd0);
        check("rst_ctrl", 32'(bus.alu_control), 32'd0);
        check("rst_rd", 32'(bus.alu_rd), 32'd0);
        check("rst_pend", 32'(dut.pending), 32'd0);

        // writeback R3, upper data bits dropped
        wb(1'b1, 3'd3, 10'h3F5);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        issue(1'b1, 2'd2, 3'd4, 3'd3, 3'd3);
        settle();
        check("add_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        check("add_valid", 32'(bus.alu_valid), 32'd1);
        check("add_a", 32'(bus.alu_a), 32'h15);
        check("add_b", 32'(bus.alu_b), 32'h15);
        check("add_ctrl", 32'(bus.alu_control), 32'd2);
        check("add_rd", 32'(bus.alu_rd), 32'd4);
        check("add_pend", 32'(dut.pending), 32'h10);

        // slot drains, payload holds
        wb(1'b1, 3'd4, 10'd0);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        check("drain_valid", 32'(bus.alu_valid), 32'd0);
        check("drain_hold_a", 32'(bus.alu_a), 32'h15);

        // RAW on r2, released by bypassing writeback
        issue(1'b1, 2'd1, 3'd2, 3'd0, 3'd3);
        tick();
        check("xor_a", 32'(bus.alu_a), 32'd0);
        check("xor_b", 32'(bus.alu_b), 32'h15);
        check("xor_ctrl", 32'(bus.alu_control), 32'd1);
        issue(1'b1, 2'd3, 3'd5, 3'd2, 3'd3);
        settle();
        check("raw_stall0", 32'(bus.in_ready), 32'd0);
        tick();
        check("raw_bubble", 32'(bus.alu_valid), 32'd0);
        check("raw_stall1", 32'(bus.in_ready), 32'd0);
        wb(1'b1, 3'd2, 10'd7);
        settle();
        check("raw_release", 32'(bus.in_ready), 32'd1);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        check("byp_valid", 32'(bus.alu_valid), 32'd1);
        check("byp_a", 32'(bus.alu_a), 32'd7);
        check("byp_b", 32'(bus.alu_b), 32'h15);
        check("byp_ctrl", 32'(bus.alu_control), 32'd3);
        check("byp_rd", 32'(bus.alu_rd), 32'd5);
        wb(1'b1, 3'd5, 10'd0);
        tick();
        wb(1'b0, 3'd0, 10'd0);

        // backpressure: slot frozen for 3 cycles
        bus.out_ready = 1'b0;
        issue(1'b1, 2'd0, 3'd1, 3'd3, 3'd2);
        tick();
        issue(1'b1, 2'd2, 3'd6, 3'd3, 3'd3);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_rdy", 32'(bus.in_ready), 32'd0);
            tick();
            check("bp_valid", 32'(bus.alu_valid), 32'd1);
            check("bp_a", 32'(bus.alu_a), 32'h15);
            check("bp_b", 32'(bus.alu_b), 32'd7);
            check("bp_rd", 32'(bus.alu_rd), 32'd1);
        end
        bus.out_ready = 1'b1;
        settle();
        check("bp_release", 32'(bus.in_ready), 32'd1);
        tick();
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        check("bp_next_valid", 32'(bus.alu_valid), 32'd1);
        check("bp_next_rd", 32'(bus.alu_rd), 32'd6);
        check("bp_next_ctrl", 32'(bus.alu_control), 32'd2);
        wb(1'b1, 3'd1, 10'd0);
        tick();
        wb(1'b1, 3'd6, 10'd0);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        check("bp_pend_clr", 32'(dut.pending), 32'd0);

        // r0 is hardwired, rd=0 never pends
        wb(1'b1, 3'd0, 10'd9);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        issue(1'b1, 2'd2, 3'd0, 3'd0, 3'd0);
        tick();
        check("r0_a", 32'(bus.alu_a), 32'd0);
        check("r0_pend", 32'(dut.pending), 32'd0);
        issue(1'b1, 2'd1, 3'd0, 3'd0, 3'd0);
        settle();
        check("r0_b2b_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        check("r0_b2b_valid", 32'(bus.alu_valid), 32'd1);
        check("r0_b2b_ctrl", 32'(bus.alu_control), 32'd1);

        // set beats same-cycle clear on r5
        issue(1'b1, 2'd3, 3'd5, 3'd3, 3'd3);
        wb(1'b1, 3'd5, 10'h1F);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        check("setwin_pend", 32'(dut.pending), 32'h20);
        issue(1'b1, 2'd2, 3'd7, 3'd0, 3'd5);
        settle();
        check("setwin_stall", 32'(bus.in_ready), 32'd0);
        wb(1'b1, 3'd5, 10'h0A);
        settle();
        check("setwin_release", 32'(bus.in_ready), 32'd1);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        check("setwin_b", 32'(bus.alu_b), 32'h0A);
        check("setwin_pend7", 32'(dut.pending), 32'h80);

        // build pending = 0x0C then reset mid-flight
        issue(1'b1, 2'd0, 3'd2, 3'd0, 3'd0);
        wb(1'b1, 3'd7, 10'd3);
        tick();
        wb(1'b0, 3'd0, 10'd0);
        issue(1'b1, 2'd0, 3'd3, 3'd0, 3'd0);
        tick();
        check("pre_rst_pend", 32'(dut.pending), 32'h0C);
        check("pre_rst_valid", 32'(bus.alu_valid), 32'd1);
        rst = 1'b1;
        issue(1'b1, 2'd2, 3'd4, 3'd3, 3'd5);
        wb(1'b1, 3'd6, 10'h11);
        tick();
        rst = 1'b0;
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        wb(1'b0, 3'd0, 10'd0);
        check("mid_rst_valid", 32'(bus.alu_valid), 32'd0);
        check("mid_rst_pend", 32'(dut.pending), 32'd0);
        check("mid_rst_a", 32'(bus.alu_a), 32'd0);
        issue(1'b1, 2'd2, 3'd1, 3'd3, 3'd5);
        settle();
        check("post_rst_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        check("post_rst_r3", 32'(bus.alu_a), 32'd0);
        check("post_rst_r5", 32'(bus.alu_b), 32'd0);
        issue(1'b1, 2'd2, 3'd4, 3'd6, 3'd7);
        tick();
        issue(1'b0, 2'd0, 3'd0, 3'd0, 3'd0);
        check("post_rst_r6", 32'(bus.alu_a), 32'd0);
        check("post_rst_r7", 32'(bus.alu_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
